// File: rtl/dmem_responder.sv
// Data-memory responder for the RV32I load/store port: one outstanding request,
// LATENCY wait states, then a byte/half/word access to a word-organised RAM.
module dmem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW         = $clog2(DEPTH);
  localparam int          CW         = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic req_error(input logic we, input logic [2:0] f3,
                                     input logic [31:0] addr);
    logic illegal;
    logic misaligned;
    if (we) begin
      illegal = f3[2] || (f3[1:0] == 2'b11);
    end else begin
      illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end
    misaligned = ((f3[1:0] == 2'b01) && addr[0]) ||
                 ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    return illegal || misaligned || (addr >= ADDR_LIMIT);
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0] f3,
                                               input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'd0;
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b100:  res = {24'd0, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b101:  res = {16'd0, h};
      3'b010:  res = word;
      default: res = 32'd0;
    endcase
    return res;
  endfunction

  // Replicated store data plus byte enables merge only the addressed lanes
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [2:0] f3,
                                              input logic [1:0] lane);
    logic [3:0]  be;
    logic [31:0] d;
    logic [31:0] res;
    case (f3[1:0])
      2'b00: begin
        be = 4'b0001 << lane;
        d  = {4{wdata[7:0]}};
      end
      2'b01: begin
        be = lane[1] ? 4'b1100 : 4'b0011;
        d  = {2{wdata[15:0]}};
      end
      2'b10: begin
        be = 4'b1111;
        d  = wdata;
      end
      default: begin
        be = 4'b0000;
        d  = 32'd0;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? d[8*i +: 8] : word[8*i +: 8];
    end
    return res;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            req_ready_q, req_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic [31:0]     mem_q [DEPTH];

  logic            use_req_s;
  logic            do_access_s;
  logic            acc_we_s;
  logic [2:0]      acc_f3_s;
  logic [31:0]     acc_addr_s;
  logic [31:0]     acc_wdata_s;
  logic            acc_err_s;
  logic [AW-1:0]   acc_idx_s;
  logic [31:0]     rd_word_s;
  logic            mem_we_s;

  // With zero wait states the access happens on the accept edge straight from the request
  assign use_req_s   = (LATENCY == 0) && (state_q == S_IDLE);
  assign acc_we_s    = use_req_s ? req_we     : we_q;
  assign acc_f3_s    = use_req_s ? req_funct3 : f3_q;
  assign acc_addr_s  = use_req_s ? req_addr   : addr_q;
  assign acc_wdata_s = use_req_s ? req_wdata  : wdata_q;
  assign acc_err_s   = req_error(acc_we_s, acc_f3_s, acc_addr_s);
  assign acc_idx_s   = acc_addr_s[AW+1:2];
  assign rd_word_s   = mem_q[acc_idx_s];
  assign mem_we_s    = do_access_s && acc_we_s && !acc_err_s;

  // Next-state, request latch and response register logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    do_access_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY == 0) begin
            do_access_s = 1'b1;
            state_d     = S_RESP;
          end else begin
            cnt_d   = CW'(LATENCY);
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          do_access_s = 1'b1;
          state_d     = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b0;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (do_access_s) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = acc_err_s;
      rsp_rdata_d = (acc_err_s || acc_we_s) ? 32'd0
                                            : load_extract(rd_word_s, acc_f3_s, acc_addr_s[1:0]);
    end else begin
      rsp_valid_d = rsp_valid_d;
    end
    req_ready_d = (state_d == S_IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      f3_q        <= 3'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // RAM write port; a store caught by reset is dropped
  always_ff @(posedge clk) begin
    if (rst && mem_we_s) begin
      mem_q[acc_idx_s] <= store_merge(rd_word_s, acc_wdata_s, acc_f3_s, acc_addr_s[1:0]);
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=0 and LATENCY=2 instances side by side,
// checked every cycle against a byte-addressed transaction model.
module tb_dmem_responder;

  localparam int DEPTH = 128;
  localparam int NB    = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [31:0] rsp_rdata [2];

  int n_tests = 0;
  int n_fail  = 0;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  function automatic bit f3_legal(input bit we, input logic [2:0] f3);
    if (we) return f3 inside {3'b000, 3'b001, 3'b010};
    return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Transaction model: one outstanding request, byte-addressed memory image
  bit          busy [2];
  int          age [2];
  logic [31:0] m_rdata [2];
  bit          m_err [2];
  bit          pend [2];
  logic [31:0] p_addr [2];
  logic [31:0] p_wdata [2];
  int          p_size [2];
  logic [7:0]  bm [2][NB];
  bit          mdl_ok = 1'b0;
  logic [31:0] m_a, m_v;
  int          m_sz;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        busy[k] = 1'b0;
        pend[k] = 1'b0;
        mdl_ok  = 1'b1;
      end else if (busy[k]) begin
        if (age[k] >= lat_of(k) + 1 && rsp_ready[k]) busy[k] = 1'b0;
        else age[k]++;
      end else if (req_valid[k]) begin
        m_a        = req_addr[k];
        m_sz       = 1 << req_funct3[k][1:0];
        busy[k]    = 1'b1;
        age[k]     = 1;
        m_rdata[k] = 32'd0;
        pend[k]    = 1'b0;
        m_err[k]   = !f3_legal(req_we[k], req_funct3[k]) || (m_a % m_sz != 0) || (m_a >= NB);
        if (!m_err[k] && req_we[k]) begin
          pend[k]    = 1'b1;
          p_addr[k]  = m_a;
          p_size[k]  = m_sz;
          p_wdata[k] = req_wdata[k];
        end else if (!m_err[k]) begin
          m_v = 32'd0;
          for (int i = 0; i < m_sz; i++) m_v = m_v | (32'(bm[k][m_a + i]) << (8 * i));
          if (!req_funct3[k][2] && m_sz < 4 && m_v[8 * m_sz - 1])
            m_v = m_v | ~((32'd1 << (8 * m_sz)) - 32'd1);
          m_rdata[k] = m_v;
        end
      end
      if (busy[k] && pend[k] && age[k] == lat_of(k) + 1) begin
        for (int i = 0; i < p_size[k]; i++) bm[k][p_addr[k] + i] = p_wdata[k][8*i +: 8];
        pend[k] = 1'b0;
      end
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (mdl_ok) begin
      for (int k = 0; k < 2; k++) begin
        bit ev;
        ev = busy[k] && (age[k] >= lat_of(k) + 1);
        chk($sformatf("cyc_ready%0d", k), 32'(req_ready[k]), 32'(!busy[k]));
        chk($sformatf("cyc_valid%0d", k), 32'(rsp_valid[k]), 32'(ev));
        chk($sformatf("cyc_rdata%0d", k), rsp_rdata[k], ev ? m_rdata[k] : 32'd0);
        chk($sformatf("cyc_err%0d", k), 32'(rsp_err[k]), ev ? 32'(m_err[k]) : 32'd0);
      end
    end
  end

  task automatic drive(input int k, input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid[k]  = 1'b1;
    req_we[k]     = we;
    req_funct3[k] = f3;
    req_addr[k]   = a;
    req_wdata[k]  = wd;
  endtask

  task automatic txn(input int k, input bit we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] exp_d, input bit exp_e,
                     input string nm, input int stall);
    int n;
    @(negedge clk);
    drive(k, we, f3, a, wd);
    @(negedge clk);
    req_valid[k] = 1'b0;
    n = 1;
    while (rsp_valid[k] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, 32'(n), 32'(lat_of(k) + 1));
    chk({nm, "_rdata"}, rsp_rdata[k], exp_d);
    chk({nm, "_err"}, 32'(rsp_err[k]), 32'(exp_e));
    if (stall > 0) begin
      drive(k, 1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF);
      repeat (stall) begin
        @(negedge clk);
        chk({nm, "_hold_valid"}, 32'(rsp_valid[k]), 32'd1);
        chk({nm, "_hold_rdata"}, rsp_rdata[k], exp_d);
        chk({nm, "_hold_ready"}, 32'(req_ready[k]), 32'd0);
      end
      req_valid[k] = 1'b0;
    end
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    rsp_ready[k] = 1'b0;
  endtask

  task automatic run_suite(input int k);
    txn(k, 1, 3'b010, 32'h10,  32'h8765_43A1, 32'h0000_0000, 0, "sw10", 0);
    txn(k, 0, 3'b010, 32'h10,  32'h0,         32'h8765_43A1, 0, "lw10", 0);
    txn(k, 0, 3'b000, 32'h10,  32'h0,         32'hFFFF_FFA1, 0, "lb10", 0);
    txn(k, 0, 3'b100, 32'h10,  32'h0,         32'h0000_00A1, 0, "lbu10", 0);
    txn(k, 0, 3'b001, 32'h12,  32'h0,         32'hFFFF_8765, 0, "lh12", 0);
    txn(k, 0, 3'b101, 32'h12,  32'h0,         32'h0000_8765, 0, "lhu12", 0);
    txn(k, 1, 3'b000, 32'h13,  32'h0000_0055, 32'h0000_0000, 0, "sb13", 0);
    txn(k, 0, 3'b010, 32'h10,  32'h0,         32'h5565_43A1, 0, "lw10_sb", 0);
    txn(k, 1, 3'b001, 32'h10,  32'h0000_BEEF, 32'h0000_0000, 0, "sh10", 0);
    txn(k, 0, 3'b010, 32'h10,  32'h0,         32'h5565_BEEF, 0, "lw10_sh", 0);
    txn(k, 1, 3'b010, 32'h00,  32'h0BAD_F00D, 32'h0000_0000, 0, "sw00", 0);
    txn(k, 0, 3'b010, 32'h11,  32'h0,         32'h0000_0000, 1, "lw11_mis", 0);
    txn(k, 1, 3'b001, 32'h01,  32'h0000_FFFF, 32'h0000_0000, 1, "sh01_mis", 0);
    txn(k, 0, 3'b010, 32'h200, 32'h0,         32'h0000_0000, 1, "lw_oob", 0);
    txn(k, 1, 3'b000, 32'h200, 32'h0000_0077, 32'h0000_0000, 1, "sb_oob", 0);
    txn(k, 1, 3'b100, 32'h00,  32'hFFFF_FFFF, 32'h0000_0000, 1, "st_f3_bad", 0);
    txn(k, 0, 3'b011, 32'h00,  32'h0,         32'h0000_0000, 1, "ld_f3_bad", 0);
    txn(k, 0, 3'b010, 32'h00,  32'h0,         32'h0BAD_F00D, 0, "lw00_keep", 0);
    txn(k, 1, 3'b010, 32'h1FC, 32'hC3C3_7E7E, 32'h0000_0000, 0, "sw1fc", 0);
    txn(k, 0, 3'b000, 32'h1FF, 32'h0,         32'hFFFF_FFC3, 0, "lb1ff", 0);
    txn(k, 0, 3'b101, 32'h1FE, 32'h0,         32'h0000_C3C3, 0, "lhu1fe", 0);
    txn(k, 0, 3'b010, 32'h10,  32'h0,         32'h5565_BEEF, 0, "lw10_bp", 5);
    txn(k, 0, 3'b010, 32'h10,  32'h0,         32'h5565_BEEF, 0, "lw10_ign", 0);
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 2'b00;
    req_we    = 2'b00;
    rsp_ready = 2'b00;
    for (int k = 0; k < 2; k++) begin
      req_funct3[k] = 3'd0;
      req_addr[k]   = 32'd0;
      req_wdata[k]  = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("init_ready%0d", k), 32'(req_ready[k]), 32'd1);
      chk($sformatf("init_valid%0d", k), 32'(rsp_valid[k]), 32'd0);
    end
    rst = 1'b1;

    // Reset in the middle of a wait drops the pending store and its response
    txn(1, 1, 3'b010, 32'h20, 32'h1111_1111, 32'h0000_0000, 0, "sw20", 0);
    @(negedge clk);
    drive(1, 1'b1, 3'b010, 32'h20, 32'h2222_2222);
    @(negedge clk);
    req_valid[1] = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready[1]), 32'd1);
    chk("rst_valid", 32'(rsp_valid[1]), 32'd0);
    chk("rst_rdata", rsp_rdata[1], 32'd0);
    chk("rst_err", 32'(rsp_err[1]), 32'd0);
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'(rsp_valid[1]), 32'd0);
    end
    txn(1, 0, 3'b010, 32'h20, 32'h0, 32'h1111_1111, 0, "lw20_rst", 0);

    run_suite(1);
    run_suite(0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
